sdram_cmd_arbiter: RTL
======================

# sdram_cmd_arbiter

Central scheduler for the SDRAM controller's shared 20-bit command/address bus. It holds off all traffic until power-up initialisation finishes and times periodic auto-refresh. It grants the bus to exactly one of the refresh, write and read sequencers at a time and drives the chosen sequencer's bus, registered, to the SDRAM pins. Every sequencer bus uses the packing {cmd[3:0], a[12:0], ba[1:0], cke}.

## Interface
- REF_PERIOD, 780: clock cycles between refresh requests (7.8 us at 100 MHz); legal range 2..32767.
- clk  in  1  100 MHz system clock.
- soft_rst  in  1  Reset. One clock; reset is synchronous and active-high.
- init_done  in  1  Level from the init sequencer; high once power-up init is complete.
- init_bus  in  20  Init sequencer command bus.
- ref_en  out  1  One-cycle start pulse to the refresh sequencer.
- ref_done  in  1  One-cycle completion pulse from the refresh sequencer.
- ref_bus  in  20  Refresh sequencer command bus.
- wr_req  in  1  Write request; level, held until wr_en.
- wr_en  out  1  One-cycle write start pulse.
- wr_done  in  1  One-cycle write completion pulse.
- wr_bus  in  20  Write sequencer command bus.
- rd_req, rd_en, rd_done, rd_bus: same as the write group, for reads.
- sdram_bus  out  20  Registered command bus to the SDRAM pins.
- ref_overflow  out  1  Sticky error: a refresh period expired while the previous refresh was still pending.

## Operation
- State machine: INIT, ARB, REF, WR, RD.
- INIT: entered on reset. Leaves for ARB when init_done=1.
- ARB: priority is ref_pending, then write/read grant, then stay in ARB.
  - Entering REF, WR or RD fires the matching *_en for exactly that first cycle.
- REF goes to ARB on ref_done. WR goes to ARB on wr_done. RD goes to ARB on rd_done.
- Done pulses are honoured only in the matching state. Done pulses in any other state are ignored.
- Bus source by state, registered into sdram_bus:
  - INIT selects init_bus.
  - REF, WR, RD select ref_bus, wr_bus, rd_bus.
  - ARB selects the NOP word {NOP, 13'd0, 2'd0, 1'b1}, using the NOP encoding from head.v.
- Refresh timer:
  - 15-bit counter, held at 0 during INIT.
  - In all other states it counts 0..REF_PERIOD-1 and wraps.
  - At terminal count it sets ref_pending.
  - ref_pending clears in the cycle ref_en fires. If set and clear hit the same cycle, set wins.
  - A terminal count while ref_pending=1 sets ref_overflow. Only reset clears ref_overflow.
- An active write or read is never pre-empted. A refresh that comes due mid-transfer waits for the done pulse, then ARB services it first.

## Timing
- Reset values:
  - state=INIT; timer=0; ref_pending=0.
  - ref_en=wr_en=rd_en=0; ref_overflow=0.
  - sdram_bus={NOP, 13'd0, 2'd0, 1'b1}.
- sdram_bus lags the selected source bus by exactly 1 cycle.
- Grant latency: request seen in ARB in cycle N → *_en high in cycle N+1.
- Turnaround: done in cycle N → ARB in N+1 → next *_en in N+2 at the earliest.
- Sequencers do not assert done earlier than 2 cycles after their en pulse.
- Simultaneous wr_req and rd_req with ref_pending=0: arbitrated per Configuration.
- Requests asserted outside ARB stay pending; no queueing beyond the held level.
- soft_rst mid-operation: everything returns to reset values next edge, state INIT. The sequencers share the same reset.

## Configuration
- SDRAM_ARB_RR_EN defined:
  - Write/read tie-break is round-robin using a last-grant flag (reset value: "read", so the first tie goes to write).
  - The flag updates on every wr_en or rd_en.
- SDRAM_ARB_RR_EN not defined:
  - Fixed priority: write over read.
  - No last-grant flag exists.
- Refresh always keeps top priority in both builds.

## Test plan
- Reset then init: hold init_done=0 for 50 cycles → sdram_bus mirrors init_bus with 1-cycle lag, timer stays 0. Raise init_done → ARB, sdram_bus=NOP word.
- Periodic refresh, REF_PERIOD=20, no traffic, sequencer model returns ref_done 10 cycles after ref_en → ref_en pulses once every 20 cycles, ref_overflow stays 0.
- Refresh during write, REF_PERIOD=20, wr_done 30 cycles after wr_en → ref_pending set mid-write, then ref_overflow=1. ref_en fires exactly 2 cycles after wr_done.
- Simultaneous wr_req=rd_req=1 held, done 5 cycles after en:
  - With SDRAM_ARB_RR_EN: grants alternate W,R,W,R.
  - Without it: W,W,W,…
- Refresh beats request: ref_pending=1 and wr_req=1 in the same ARB cycle → ref_en first, wr_en 2 cycles after ref_done.
- soft_rst pulsed mid-read → next cycle state INIT, all *_en=0, sdram_bus=NOP word, ref_overflow=0.

Source files
------------

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command-bus scheduler: init gate, auto-refresh timer, ref/wr/rd grant.
// Build option SDRAM_ARB_RR_EN: round-robin write/read tie-break (default: write first).
module sdram_cmd_arbiter #(
  parameter int REF_PERIOD = 780
) (
  input  logic        clk,
  input  logic        soft_rst,
  input  logic        init_done,
  input  logic [19:0] init_bus,
  output logic        ref_en,
  input  logic        ref_done,
  input  logic [19:0] ref_bus,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        wr_done,
  input  logic [19:0] wr_bus,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        rd_done,
  input  logic [19:0] rd_bus,
  output logic [19:0] sdram_bus,
  output logic        ref_overflow
);

  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [19:0] NOP_WORD = {CMD_NOP, 13'd0, 2'd0, 1'b1};
  localparam logic [14:0] TMR_LAST = 15'(REF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_ARB,
    S_REF,
    S_WR,
    S_RD
  } state_e;

  state_e      state_q, state_d;
  logic [14:0] tmr_q, tmr_d;
  logic        ref_pend_q, ref_pend_d;
  logic        ovf_q, ovf_d;
  logic        ref_en_q, ref_en_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic [19:0] bus_q, bus_d;
  logic        tmr_tc;
  logic        grant_wr;

`ifdef SDRAM_ARB_RR_EN
  // Remembers who won last; reset as "read" so the first tie goes to write.
  logic last_rd_q, last_rd_d;

  always_comb begin
    last_rd_d = last_rd_q;
    if (wr_en_q)
      last_rd_d = 1'b0;
    else if (rd_en_q)
      last_rd_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (soft_rst)
      last_rd_q <= 1'b1;
    else
      last_rd_q <= last_rd_d;
  end

  assign grant_wr = wr_req && (!rd_req || last_rd_q);
`else
  assign grant_wr = wr_req;
`endif

  // Refresh timer runs in every state except INIT.
  always_comb begin
    tmr_tc = (state_q != S_INIT) && (tmr_q == TMR_LAST);
    if (state_q == S_INIT || tmr_tc)
      tmr_d = 15'd0;
    else
      tmr_d = tmr_q + 15'd1;
    ref_pend_d = tmr_tc | (ref_pend_q & ~ref_en_q);
    ovf_d      = ovf_q | (tmr_tc & ref_pend_q);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT: if (init_done) state_d = S_ARB;
      S_ARB: begin
        if (ref_pend_q)
          state_d = S_REF;
        else if (grant_wr)
          state_d = S_WR;
        else if (rd_req)
          state_d = S_RD;
      end
      S_REF: if (ref_done) state_d = S_ARB;
      S_WR:  if (wr_done)  state_d = S_ARB;
      S_RD:  if (rd_done)  state_d = S_ARB;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    ref_en_d = 1'b0;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    if (state_q == S_ARB) begin
      ref_en_d = (state_d == S_REF);
      wr_en_d  = (state_d == S_WR);
      rd_en_d  = (state_d == S_RD);
    end
    unique case (state_q)
      S_INIT:  bus_d = init_bus;
      S_REF:   bus_d = ref_bus;
      S_WR:    bus_d = wr_bus;
      S_RD:    bus_d = rd_bus;
      default: bus_d = NOP_WORD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q    <= S_INIT;
      tmr_q      <= 15'd0;
      ref_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      ref_en_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      bus_q      <= NOP_WORD;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      ref_pend_q <= ref_pend_d;
      ovf_q      <= ovf_d;
      ref_en_q   <= ref_en_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      bus_q      <= bus_d;
    end
  end

  assign ref_en       = ref_en_q;
  assign wr_en        = wr_en_q;
  assign rd_en        = rd_en_q;
  assign sdram_bus    = bus_q;
  assign ref_overflow = ovf_q;

endmodule
